// File: rtl/vu_mult_acc_pkg.sv
// Shared definitions for the vu_mult_acc multiply-accumulate back end:
// op encodings, datapath widths, clamp limits and the clamp helper.
package vu_mult_acc_pkg;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 48;
    localparam int RES_W  = 16;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MAC  = 2'b01,
        OP_READ = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    // Limits of the signed 16-bit result window, in result and 32-bit form.
    localparam logic [RES_W-1:0]  CLAMP_POS   = 16'h7FFF;
    localparam logic [RES_W-1:0]  CLAMP_NEG   = 16'h8000;
    localparam logic signed [31:0] CLAMP_POS_W = 32'sh0000_7FFF;
    localparam logic signed [31:0] CLAMP_NEG_W = 32'shFFFF_8000;

    // Signed saturation of ACC[47:16] into 16 bits.
    function automatic logic [RES_W-1:0] clamp_slice(input logic [31:0] hi_w);
        logic signed [31:0] w;
        w = $signed(hi_w);
        if (w > CLAMP_POS_W)
            return CLAMP_POS;
        else if (w < CLAMP_NEG_W)
            return CLAMP_NEG;
        else
            return hi_w[RES_W-1:0];
    endfunction

endpackage

// File: rtl/vu_mult_acc_cpa.sv
// Carry-propagate adder for vu_mult_acc: merges the CSA sum/carry vectors
// into the 32-bit product, extends it to 48 bits and adds it to the
// accumulator. Purely combinational.
module vu_mult_acc_cpa
    import vu_mult_acc_pkg::*;
(
    input  logic [PROD_W-1:0] sum_i,
    input  logic [PROD_W-1:0] carry_i,
    input  logic              signed_i,
    input  logic [ACC_W-1:0]  acc_i,
    output logic [ACC_W-1:0]  ext_o,
    output logic [ACC_W-1:0]  mac_o
);

    logic [PROD_W-1:0] prod;
    logic              fill;

    assign prod  = sum_i + carry_i;
    assign fill  = signed_i & prod[PROD_W-1];
    assign ext_o = {{(ACC_W-PROD_W){fill}}, prod};
    // Accumulate wraps modulo 2^48; the carry out is deliberately dropped.
    assign mac_o = acc_i + ext_o;

endmodule

// File: rtl/vu_mult_acc.sv
// vu_mult_acc: two-stage multiply-accumulate back end. S1 registers the
// multiplier CSA outputs and the op; S2 merges the product, updates the
// 48-bit accumulator and registers the 16-bit result slice.
// Build option: VU_MULT_ACC_CLAMP_EN enables signed saturation of res;
// without it res is the plain ACC[31:16] slice.
module vu_mult_acc
    import vu_mult_acc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] sumlower,
    input  logic [15:0] carrylower,
    input  logic [15:0] sumupper,
    input  logic [15:0] carryupper,
    input  logic        prod_signed,
    input  logic [1:0]  op,
    input  logic        stall,
    output logic        out_valid,
    output logic [15:0] res,
    output logic [15:0] acc_hi
);

    logic              s1_valid_q;
    logic [PROD_W-1:0] s1_sum_q;
    logic [PROD_W-1:0] s1_carry_q;
    logic              s1_signed_q;
    op_e               s1_op_q;

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  ext;
    logic [ACC_W-1:0]  mac;
    logic [RES_W-1:0]  res_d;
    logic              out_valid_q;
    logic [RES_W-1:0]  res_q;
    logic [RES_W-1:0]  acc_hi_q;

    // Stage 1: capture the CSA vectors and op unless stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_carry_q  <= '0;
            s1_signed_q <= 1'b0;
            s1_op_q     <= OP_MUL;
        end else if (!stall) begin
            s1_valid_q  <= in_valid;
            s1_sum_q    <= {sumupper, sumlower};
            s1_carry_q  <= {carryupper, carrylower};
            s1_signed_q <= prod_signed;
            s1_op_q     <= op_e'(op);
        end
    end

    vu_mult_acc_cpa u_cpa (
        .sum_i    (s1_sum_q),
        .carry_i  (s1_carry_q),
        .signed_i (s1_signed_q),
        .acc_i    (acc_q),
        .ext_o    (ext),
        .mac_o    (mac)
    );

    // Next accumulator value; CLR ignores whatever product came with it.
    always_comb begin
        acc_d = acc_q;
        case (s1_op_q)
            OP_MUL:  acc_d = ext;
            OP_MAC:  acc_d = mac;
            OP_READ: acc_d = acc_q;
            OP_CLR:  acc_d = '0;
            default: acc_d = acc_q;
        endcase
    end

    // Result slice taken from the new accumulator value.
`ifdef VU_MULT_ACC_CLAMP_EN
    assign res_d = clamp_slice(acc_d[ACC_W-1:RES_W]);
`else
    assign res_d = acc_d[2*RES_W-1:RES_W];
`endif

    // Stage 2: commit the accumulator and register the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            acc_hi_q    <= '0;
        end else if (!stall) begin
            if (s1_valid_q) begin
                acc_q       <= acc_d;
                out_valid_q <= 1'b1;
                res_q       <= res_d;
                acc_hi_q    <= acc_d[ACC_W-1:2*RES_W];
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign acc_hi    = acc_hi_q;

endmodule

// File: tb/tb_vu_mult_acc.sv
// Scoreboard bench for vu_mult_acc: the driver pushes expected results from
// a plain-arithmetic accumulator model; a monitor pops on every new output.
module tb_vu_mult_acc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] sumlower, carrylower, sumupper, carryupper;
    logic        prod_signed;
    logic [1:0]  op;
    logic        stall;
    logic        out_valid;
    logic [15:0] res;
    logic [15:0] acc_hi;

    vu_mult_acc dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .sumlower    (sumlower),
        .carrylower  (carrylower),
        .sumupper    (sumupper),
        .carryupper  (carryupper),
        .prod_signed (prod_signed),
        .op          (op),
        .stall       (stall),
        .out_valid   (out_valid),
        .res         (res),
        .acc_hi      (acc_hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic [15:0] h;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_stall_cyc = -1;
    int          n_out    = 0;
    logic [15:0] last_res = '0;
    logic [15:0] last_hi  = '0;
    logic [47:0] model_acc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: accumulator semantics computed with plain arithmetic.
    task automatic model_op(input logic [31:0] s, input logic [31:0] c,
                            input logic sg, input logic [1:0] o);
        logic [31:0]        p;
        logic [47:0]        e;
        logic signed [31:0] w;
        exp_t               x;
        p = s + c;
        if (sg && p[31]) e = {16'hFFFF, p};
        else             e = {16'h0000, p};
        case (o)
            2'b00:   model_acc = e;
            2'b01:   model_acc = model_acc + e;
            2'b10:   model_acc = model_acc;
            default: model_acc = 48'h0;
        endcase
        w = $signed(model_acc[47:16]);
`ifdef VU_MULT_ACC_CLAMP_EN
        if (w > 32767)       x.r = 16'h7FFF;
        else if (w < -32768) x.r = 16'h8000;
        else                 x.r = model_acc[31:16];
`else
        x.r = model_acc[31:16];
`endif
        x.h   = model_acc[47:32];
        x.cyc = cyc;
        sb_q.push_back(x);
    endtask

    task automatic step(input logic v, input logic [31:0] s, input logic [31:0] c,
                        input logic sg, input logic [1:0] o, input logic st);
        in_valid = v;
        {sumupper, sumlower}     = s;
        {carryupper, carrylower} = c;
        prod_signed = sg;
        op    = o;
        stall = st;
        @(posedge clk);
        #1;
        if (!reset && !st && v) model_op(s, c, sg, o);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        model_acc = '0;
        reset = 1'b0;
    endtask

    // Monitor: pop on each newly presented output, otherwise require hold.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            sb_q.delete();
            last_res = '0;
            last_hi  = '0;
            chk("reset_out_valid", {47'h0, out_valid}, 48'h0);
            chk("reset_res", {32'h0, res}, 48'h0);
            chk("reset_acc_hi", {32'h0, acc_hi}, 48'h0);
        end else if (!stall && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", {47'h0, out_valid}, 48'h0);
            end else begin
                exp_t x;
                x = sb_q.pop_front();
                n_out++;
                chk("res", {32'h0, res}, {32'h0, x.r});
                chk("acc_hi", {32'h0, acc_hi}, {32'h0, x.h});
                if (last_stall_cyc < x.cyc) chk("latency", cyc, x.cyc + 1);
                last_res = x.r;
                last_hi  = x.h;
            end
        end else begin
            if (stall) last_stall_cyc = cyc;
            chk("hold_res", {32'h0, res}, {32'h0, last_res});
            chk("hold_acc_hi", {32'h0, acc_hi}, {32'h0, last_hi});
        end
    end

    initial begin
        int snap;
        logic [31:0] s, c;
        reset = 1'b1;
        in_valid = 1'b0; sumlower = '0; carrylower = '0; sumupper = '0; carryupper = '0;
        prod_signed = 1'b0; op = 2'b00; stall = 1'b0;
        #2;
        do_reset(3);
        idle(1);

        // Basic MUL, carry merge across halves
        step(1'b1, 32'h0003_0000, 32'h0, 1'b1, 2'b00, 1'b0);
        step(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 2'b00, 1'b0);
        idle(2);

        // Clamp boundary: 0x7FFF + 1 in the result slice
        step(1'b1, 32'h7FFF_0000, 32'h0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 32'h0001_0000, 32'h0, 1'b1, 2'b01, 1'b0);
        idle(2);

        // Sign vs zero extension of a negative product
        step(1'b1, 32'hFFFF_0000, 32'h0, 1'b1, 2'b00, 1'b0);
        step(1'b1, 32'hFFFF_0000, 32'h0, 1'b0, 2'b00, 1'b0);
        idle(2);

        // Back-to-back MACs with a two-cycle stall mid-stream
        step(1'b1, 32'h1234_5678, 32'h1, 1'b0, 2'b11, 1'b0);
        idle(3);
        snap = n_out;
        step(1'b1, 32'h0001_0000, 32'h0, 1'b1, 2'b01, 1'b0);
        step(1'b1, 32'h0001_0000, 32'h0, 1'b1, 2'b01, 1'b0);
        step(1'b1, 32'h0001_0000, 32'h0, 1'b1, 2'b01, 1'b1);
        step(1'b1, 32'h0001_0000, 32'h0, 1'b1, 2'b01, 1'b1);
        step(1'b1, 32'h0001_0000, 32'h0, 1'b1, 2'b01, 1'b0);
        idle(4);
        chk("mac_pulses", n_out - snap, 3);
        chk("mac_final_res", {32'h0, last_res}, 48'h3);

        // Reset one cycle after a MUL issues: nothing may come out
        step(1'b1, 32'h0005_0000, 32'h0, 1'b0, 2'b00, 1'b0);
        do_reset(1);
        snap = n_out;
        idle(3);
        chk("no_late_out_valid", n_out - snap, 0);
        step(1'b1, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0);
        idle(2);
        chk("read_after_reset", {32'h0, last_res}, 48'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                s = $urandom;
                c = $urandom;
            end else begin
                s = $urandom_range(0, 32'h0003_FFFF);
                c = $urandom_range(0, 32'h0001_FFFF);
                if ($urandom_range(0, 3) == 0) s = ~s;
            end
            step($urandom_range(0, 9) != 0, s, c, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) do_reset(1);
        end
        idle(4);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vu_mult_acc.md
VU_MULT_ACC -- requirements
Module: vu_mult_acc

Interface
REQ-001 SHALL have ports: clk, input, 1, the only clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port: in_valid, input, 1, the multiplier CSA outputs are valid this cycle.
REQ-004 SHALL have port: sumlower, input, 16, CSA sum bits [15:0] of the product.
REQ-005 SHALL have port: carrylower, input, 16, CSA carry bits [15:0] of the product.
REQ-006 SHALL have port: sumupper, input, 16, CSA sum bits [31:16] of the product.
REQ-007 SHALL have port: carryupper, input, 16, CSA carry bits [31:16] of the product.
REQ-008 SHALL have port: prod_signed, input, 1, 1 selects sign-extension of the product; 0 selects zero-extension.
REQ-009 SHALL have port: op, input, 2, accumulator operation: MUL=00, MAC=01, READ=10, CLR=11.
REQ-010 SHALL have port: stall, input, 1, freezes both pipeline stages and the accumulator.
REQ-011 SHALL have port: out_valid, output, 1, res is valid.
REQ-012 SHALL have port: res, output, 16, clamped (or truncated) accumulator slice.
REQ-013 SHALL have port: acc_hi, output, 16, accumulator bits [47:32], for debug.

Function
REQ-014 SHALL register the in_valid, sum, carry, prod_signed and op inputs in stage 1 (S1) when stall=0.
REQ-015 SHALL form, in S2, the product P = ({sumupper,sumlower} + {carryupper,carrylower}) mod 2^32.
REQ-016 SHALL form the 48-bit extension E of P: P[31] replicated when prod_signed=1, zeros otherwise.
REQ-017 SHALL update the accumulator ACC at the S2 edge when S1 is valid and stall=0, as follows:
- MUL: ACC=E
- MAC: ACC=(ACC+E) mod 2^48, wrapping silently
- READ: ACC unchanged
- CLR: ACC=0
REQ-018 SHALL present out_valid and res 2 cycles after in_valid is sampled, with no stalls in between.
REQ-019 SHALL compute res from the new ACC value, bits [31:16], with saturation per REQ-028.
REQ-020 SHALL, while stall=1, hold every register, out_valid, res and acc_hi unchanged.
REQ-021 SHALL clear out_valid when S1 is invalid and stall=0.
REQ-022 SHALL apply a CLR issued with any product to the op only; the product is ignored.
REQ-023 SHALL sustain back-to-back MAC at one op per cycle with no bubble.

Reset
REQ-024 SHALL, when reset=1 at a clock edge, clear ACC, the S1 valid bit, out_valid, res and acc_hi to 0, regardless of stall.
REQ-025 SHALL discard any operation in flight when reset is asserted mid-operation; no late out_valid.
REQ-026 SHALL accept a new op on the first cycle after reset deasserts.

Configuration
REQ-027 SHALL use the macro VU_MULT_ACC_CLAMP_EN.
REQ-028 With VU_MULT_ACC_CLAMP_EN defined, SHALL saturate res as a signed clamp of ACC[47:16]:
- >0x7FFF gives 0x7FFF
- <-0x8000 gives 0x8000
- otherwise ACC[31:16]
REQ-029 With VU_MULT_ACC_CLAMP_EN undefined, SHALL drive res=ACC[31:16] unconditionally, with no clamp logic.

Structure
REQ-030 SHALL keep the following in package vu_mult_acc_pkg:
- op encodings (MUL, MAC, READ, CLR)
- widths: PROD_W=32, ACC_W=48, RES_W=16
- the clamp limits
REQ-031 SHALL place the 48-bit carry-propagate adder (the product merge and the accumulate) in one sub-module, vu_mult_acc_cpa.

Verification
REQ-032 SHALL cover: MUL with sum=0x0003_0000, carry=0, signed -> res=0x0003 after 2 cycles, acc_hi=0x0000.
REQ-033 SHALL cover: MUL with sum=0x0000_FFFF, carry=0x0000_0001 -> P=0x0001_0000, res=0x0001 (carry merge across halves).
REQ-034 SHALL cover: ACC=0x0000_7FFF_0000, then MAC with P=0x0001_0000:
- clamp on: res=0x7FFF
- clamp off: res=0x8000
- acc_hi=0x0000 in both cases
REQ-035 SHALL cover: MUL with P=0xFFFF_0000 and prod_signed=1 -> res=0xFFFF, acc_hi=0xFFFF; the same with prod_signed=0 -> res=0x7FFF (clamp on), acc_hi=0x0000.
REQ-036 SHALL cover: 3 back-to-back MACs of 0x0001_0000, with stall=1 for 2 cycles mid-stream -> outputs held during the stall, final res=0x0003, exactly 3 out_valid pulses.
REQ-037 SHALL cover: reset asserted one cycle after a MUL issues -> out_valid stays 0, ACC=0; a following READ gives res=0x0000.
